// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port unified-memory arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_RD_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    ARB_PORT_CORE = 1'b0,
    ARB_PORT_LOAD = 1'b1
  } arb_port_e;

  localparam int unsigned LAT_W        = 2;
  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 3;

  // The latency counter is LAT_W bits wide, so only 1..3 cycles are representable.
  function automatic bit read_lat_ok(input int unsigned lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req0_valid;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req0_rvalid;
  logic [DATA_W-1:0] req0_rdata;

  logic              req1_valid;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              req1_rvalid;
  logic [DATA_W-1:0] req1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  // Requesters plus the memory model.
  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, req0_rvalid, req0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, req1_rvalid, req1_rdata,
    input  mem_addr, mem_we, mem_wdata, busy,
    output mem_rdata
  );

  // The arbiter itself.
  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, req0_rvalid, req0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, req1_rvalid, req1_rdata,
    output mem_addr, mem_we, mem_wdata, busy,
    input  mem_rdata
  );
endinterface

// File: rtl/arb_rr_pick2.sv
// Two-requester pick: single valid wins; on a tie, round-robin or fixed port 0.
module arb_rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic      valid0_i,
  input  logic      valid1_i,
  input  arb_port_e last_gnt_i,
  input  logic      rr_en_i,
  output logic      gnt_valid_o_c,
  output arb_port_e gnt_id_o_c
);

  always_comb begin : p_pick
    gnt_valid_o_c = valid0_i | valid1_i;
    gnt_id_o_c    = ARB_PORT_CORE;
    if (valid0_i && valid1_i) begin
      if (rr_en_i && (last_gnt_i == ARB_PORT_CORE)) begin
        gnt_id_o_c = ARB_PORT_LOAD;
      end
    end else if (valid1_i) begin
      gnt_id_o_c = ARB_PORT_LOAD;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between the core and the loader port,
// holding reads for the memory's fixed latency and steering data to the owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 1,
  parameter bit          RR_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus_if
);

  if (!read_lat_ok(READ_LAT)) begin : g_bad_read_lat
    $error("mem_port_arbiter: READ_LAT=%0d is outside 1..3", READ_LAT);
  end

  arb_state_e        state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  arb_port_e         owner_q, owner_d;
  arb_port_e         last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic              gnt_valid_c;
  arb_port_e         gnt_id_c;
  logic              win_we_c;
  logic [ADDR_W-1:0] win_addr_c;
  logic [DATA_W-1:0] win_wdata_c;

  logic              ready0_c, ready1_c;
  logic              rvalid0_c, rvalid1_c;
  logic              mem_we_c, busy_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  // Requests are masked while reset is held so every output reads 0.
  arb_rr_pick2 u_pick (
    .valid0_i      (bus_if.req0_valid & ~rst),
    .valid1_i      (bus_if.req1_valid & ~rst),
    .last_gnt_i    (last_gnt_q),
    .rr_en_i       (RR_EN),
    .gnt_valid_o_c (gnt_valid_c),
    .gnt_id_o_c    (gnt_id_c)
  );

  always_comb begin : p_win_mux
    win_we_c    = bus_if.req0_we;
    win_addr_c  = bus_if.req0_addr;
    win_wdata_c = bus_if.req0_wdata;
    if (gnt_id_c == ARB_PORT_LOAD) begin
      win_we_c    = bus_if.req1_we;
      win_addr_c  = bus_if.req1_addr;
      win_wdata_c = bus_if.req1_wdata;
    end
  end

  always_comb begin : p_fsm_next
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    owner_d     = owner_q;
    last_gnt_d  = last_gnt_q;
    rd_addr_d   = rd_addr_q;
    ready0_c    = 1'b0;
    ready1_c    = 1'b0;
    rvalid0_c   = 1'b0;
    rvalid1_c   = 1'b0;
    mem_addr_c  = '0;
    mem_we_c    = 1'b0;
    mem_wdata_c = '0;
    busy_c      = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_valid_c) begin
          ready0_c    = (gnt_id_c == ARB_PORT_CORE);
          ready1_c    = (gnt_id_c == ARB_PORT_LOAD);
          mem_addr_c  = win_addr_c;
          mem_we_c    = win_we_c;
          mem_wdata_c = win_wdata_c;
          last_gnt_d  = gnt_id_c;
          owner_d     = gnt_id_c;
          // Writes complete in the accept cycle; only reads occupy the port.
          if (!win_we_c) begin
            state_d   = ARB_RD_WAIT;
            lat_cnt_d = LAT_W'(READ_LAT);
            rd_addr_d = win_addr_c;
          end
        end
      end
      ARB_RD_WAIT: begin
        busy_c     = 1'b1;
        mem_addr_c = rd_addr_q;
        lat_cnt_d  = lat_cnt_q - LAT_W'(1);
        if (lat_cnt_q == LAT_W'(1)) begin
          rvalid0_c = (owner_q == ARB_PORT_CORE);
          rvalid1_c = (owner_q == ARB_PORT_LOAD);
          state_d   = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : p_state
    if (rst) begin
      state_q    <= ARB_IDLE;
      lat_cnt_q  <= '0;
      owner_q    <= ARB_PORT_CORE;
      last_gnt_q <= ARB_PORT_LOAD;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign bus_if.req0_ready  = ready0_c;
  assign bus_if.req1_ready  = ready1_c;
  assign bus_if.req0_rvalid = rvalid0_c;
  assign bus_if.req1_rvalid = rvalid1_c;
  assign bus_if.req0_rdata  = rvalid0_c ? bus_if.mem_rdata : '0;
  assign bus_if.req1_rdata  = rvalid1_c ? bus_if.mem_rdata : '0;
  assign bus_if.mem_addr    = mem_addr_c;
  assign bus_if.mem_we      = mem_we_c;
  assign bus_if.mem_wdata   = mem_wdata_c;
  assign bus_if.busy        = busy_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three configurations driven from request queues and
// compared every cycle against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int NI    = 3;
  localparam int NRAND = 120;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          at;
    int          hold;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  req_t rq   [NI][2][$];
  req_t cur  [NI][2];
  logic act  [NI][2];
  int   held [NI][2];

  logic        m_pend [NI];
  int          m_t    [NI];
  logic [31:0] m_addr [NI];
  logic        m_own  [NI];
  logic        m_last [NI];
  logic [31:0] mem_m  [logic [33:0]];

  int          gnt_port [NI][$];
  int          gnt_cyc  [NI][$];
  int          rd_port  [NI][$];
  int          rd_cyc   [NI][$];
  logic [31:0] rd_data  [NI][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int g, input logic [31:0] act_v,
                       input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", nm, g, cyc, act_v, exp_v);
    end
  endtask

  function automatic logic [31:0] mem_rd(input int g, input logic [31:0] a);
    logic [33:0] k;
    k = {2'(g), a};
    if (mem_m.exists(k)) return mem_m[k];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic req_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input int at, input int hold);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d; r.at = at; r.hold = hold;
    return r;
  endfunction

  function automatic bit quiet();
    for (int g = 0; g < NI; g++) begin
      if (m_pend[g]) return 1'b0;
      for (int p = 0; p < 2; p++)
        if (act[g][p] || rq[g][p].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic wait_quiet(input string nm, input int budget);
    int n;
    n = 0;
    while (!quiet() && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check(nm, 0, 32'(quiet()), 32'd1);
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned RL = (g == 0) ? 1 : (g == 1) ? 3 : 2;
    localparam bit          RR = (g != 2);

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bi ();

    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .READ_LAT(RL), .RR_EN(RR)
    ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bi)
    );

    initial begin
      act[g][0] = 1'b0; act[g][1] = 1'b0;
      cur[g][0] = '0;   cur[g][1] = '0;
      m_pend[g] = 1'b0; m_last[g] = 1'b1; m_own[g] = 1'b0; m_t[g] = 0; m_addr[g] = '0;
    end

    // Requester agents, reference model and per-cycle compare, all at the falling edge.
    always @(negedge clk) begin : p_model
      logic        e_rdy0, e_rdy1, e_rv0, e_rv1, e_we, e_busy, chk_wd;
      logic [31:0] e_addr, e_wdata, e_rd0, e_rd1, e_mrd;
      int          w;
      for (int p = 0; p < 2; p++) begin
        if (!act[g][p] && rq[g][p].size() != 0 && rq[g][p][0].at <= cyc) begin
          cur[g][p]  = rq[g][p].pop_front();
          act[g][p]  = 1'b1;
          held[g][p] = 0;
        end
      end
      bi.req0_valid = act[g][0];
      bi.req0_we    = cur[g][0].we;
      bi.req0_addr  = cur[g][0].addr;
      bi.req0_wdata = cur[g][0].wdata;
      bi.req1_valid = act[g][1];
      bi.req1_we    = cur[g][1].we;
      bi.req1_addr  = cur[g][1].addr;
      bi.req1_wdata = cur[g][1].wdata;

      e_rdy0 = 0; e_rdy1 = 0; e_rv0 = 0; e_rv1 = 0; e_we = 0; e_busy = 0; chk_wd = 1;
      e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0; e_mrd = $urandom;
      if (rst) begin
        m_pend[g] = 1'b0;
        m_last[g] = 1'b1;
      end else if (m_pend[g] && cyc <= m_t[g] + int'(RL)) begin
        e_addr = m_addr[g];
        e_busy = (cyc > m_t[g]);
        chk_wd = 0;
        if (cyc == m_t[g] + int'(RL)) begin
          e_mrd = mem_rd(g, m_addr[g]);
          if (m_own[g]) begin e_rv1 = 1; e_rd1 = e_mrd; end
          else          begin e_rv0 = 1; e_rd0 = e_mrd; end
        end
      end else begin
        m_pend[g] = 1'b0;
        if (act[g][0] || act[g][1]) begin
          if (act[g][0] && act[g][1]) w = (RR && !m_last[g]) ? 1 : 0;
          else                        w = act[g][1] ? 1 : 0;
          e_rdy0  = (w == 0);
          e_rdy1  = (w == 1);
          e_addr  = cur[g][w].addr;
          e_we    = cur[g][w].we;
          e_wdata = cur[g][w].wdata;
          m_last[g] = (w == 1);
          if (cur[g][w].we) begin
            mem_m[{2'(g), cur[g][w].addr}] = cur[g][w].wdata;
          end else begin
            m_pend[g] = 1'b1;
            m_t[g]    = cyc;
            m_addr[g] = cur[g][w].addr;
            m_own[g]  = (w == 1);
          end
        end
      end
      bi.mem_rdata = e_mrd;

      #1;
      check("ready0",   g, 32'(bi.req0_ready),  32'(e_rdy0));
      check("ready1",   g, 32'(bi.req1_ready),  32'(e_rdy1));
      check("rvalid0",  g, 32'(bi.req0_rvalid), 32'(e_rv0));
      check("rvalid1",  g, 32'(bi.req1_rvalid), 32'(e_rv1));
      check("rdata0",   g, bi.req0_rdata, e_rd0);
      check("rdata1",   g, bi.req1_rdata, e_rd1);
      check("mem_addr", g, bi.mem_addr,   e_addr);
      check("mem_we",   g, 32'(bi.mem_we), 32'(e_we));
      check("busy",     g, 32'(bi.busy),   32'(e_busy));
      if (chk_wd) check("mem_wdata", g, bi.mem_wdata, e_wdata);

      if (bi.req0_ready === 1'b1) begin gnt_port[g].push_back(0); gnt_cyc[g].push_back(cyc); end
      if (bi.req1_ready === 1'b1) begin gnt_port[g].push_back(1); gnt_cyc[g].push_back(cyc); end
      if (bi.req0_rvalid === 1'b1) begin
        rd_port[g].push_back(0); rd_cyc[g].push_back(cyc); rd_data[g].push_back(bi.req0_rdata);
      end
      if (bi.req1_rvalid === 1'b1) begin
        rd_port[g].push_back(1); rd_cyc[g].push_back(cyc); rd_data[g].push_back(bi.req1_rdata);
      end

      // Accepted requests retire; a few are abandoned after their hold budget.
      for (int p = 0; p < 2; p++) begin
        if (act[g][p]) begin
          if ((p == 0) ? e_rdy0 : e_rdy1) begin
            act[g][p] = 1'b0;
          end else begin
            held[g][p]++;
            if (cur[g][p].hold != 0 && held[g][p] >= cur[g][p].hold) act[g][p] = 1'b0;
          end
        end
      end
    end
  end

  initial begin : p_main
    int rel, b0, b2, bc, nr, b1, n_rd, n, t;
    req_t r;
    rst = 1'b0;
    #1 rst = 1'b1;

    // Reset release with a read already waiting on port 0; port 1 arrives one cycle later.
    for (int g = 0; g < NI; g++) begin
      mem_m[{2'(g), 32'h40}] = 32'hDEAD_BEEF;
      rq[g][0].push_back(mk(1'b0, 32'h40, 32'h0, 0, 0));
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    rel = cyc;
    for (int g = 0; g < NI; g++) rq[g][1].push_back(mk(1'b0, 32'h80, 32'h0, rel + 1, 0));
    wait_quiet("settle_a", 200);
    check("a_gnt0_port", 0, 32'(gnt_port[0][0]), 32'd0);
    check("a_gnt0_cyc",  0, 32'(gnt_cyc[0][0] - rel), 32'd0);
    check("a_rd_cyc",    0, 32'(rd_cyc[0][0] - rel), 32'd1);
    check("a_rd_data",   0, rd_data[0][0], 32'hDEAD_BEEF);
    check("a_p1_cyc",    0, 32'(gnt_cyc[0][1] - rel), 32'd2);
    check("a_rd_cyc",    1, 32'(rd_cyc[1][0] - rel), 32'd3);
    check("a_rd_data",   1, rd_data[1][0], 32'hDEAD_BEEF);
    check("a_p1_cyc",    1, 32'(gnt_cyc[1][1] - rel), 32'd4);
    check("a_p1_port",   1, 32'(gnt_port[1][1]), 32'd1);

    // Both ports hammer reads: alternating grants with round-robin, port 0 first otherwise.
    b0 = gnt_port[0].size();
    b2 = gnt_port[2].size();
    for (int g = 0; g < NI; g++)
      for (int k = 0; k < 4; k++) begin
        rq[g][0].push_back(mk(1'b0, 32'(k * 8), 32'h0, cyc, 0));
        rq[g][1].push_back(mk(1'b0, 32'(k * 8 + 4), 32'h0, cyc, 0));
      end
    wait_quiet("settle_b", 400);
    check("b_cnt", 0, 32'(gnt_port[0].size() - b0), 32'd8);
    check("b_cnt", 2, 32'(gnt_port[2].size() - b2), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check("b_rr_order",    0, 32'(gnt_port[0][b0 + k]), 32'(k % 2));
      check("b_fixed_order", 2, 32'(gnt_port[2][b2 + k]), (k < 4) ? 32'd0 : 32'd1);
    end

    // Back-to-back loader writes, then a core read of the second address.
    bc = gnt_port[0].size();
    nr = rd_data[0].size();
    rq[0][1].push_back(mk(1'b1, 32'h0, 32'h11, cyc, 0));
    rq[0][1].push_back(mk(1'b1, 32'h4, 32'h22, cyc, 0));
    rq[0][0].push_back(mk(1'b0, 32'h4, 32'h0, cyc + 4, 0));
    wait_quiet("settle_c", 200);
    check("c_w1_port", 0, 32'(gnt_port[0][bc]), 32'd1);
    check("c_w2_port", 0, 32'(gnt_port[0][bc + 1]), 32'd1);
    check("c_w_gap",   0, 32'(gnt_cyc[0][bc + 1] - gnt_cyc[0][bc]), 32'd1);
    check("c_rd_cnt",  0, 32'(rd_data[0].size() - nr), 32'd1);
    check("c_rd_data", 0, rd_data[0][nr], 32'h22);

    // Reset lands one cycle into a READ_LAT=3 read; that read must never return.
    b1 = gnt_port[1].size();
    rq[1][0].push_back(mk(1'b0, 32'h8, 32'h0, cyc, 0));
    n = 0;
    while (gnt_port[1].size() == b1 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("d_gnt", 1, 32'(gnt_port[1].size()), 32'(b1 + 1));
    rst  = 1'b1;
    n_rd = rd_port[1].size();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (6) @(posedge clk);
    check("d_no_rvalid", 1, 32'(rd_port[1].size()), 32'(n_rd));
    b1 = gnt_port[1].size();
    rq[1][0].push_back(mk(1'b0, 32'hC, 32'h0, cyc, 0));
    rq[1][1].push_back(mk(1'b0, 32'h10, 32'h0, cyc, 0));
    wait_quiet("settle_d", 200);
    check("d_tie_first",  1, 32'(gnt_port[1][b1]), 32'd0);
    check("d_tie_second", 1, 32'(gnt_port[1][b1 + 1]), 32'd1);

    // Random mixed traffic on every configuration, including abandoned requests.
    for (int g = 0; g < NI; g++)
      for (int p = 0; p < 2; p++) begin
        t = cyc;
        for (int k = 0; k < NRAND; k++) begin
          t = t + int'($urandom_range(0, 3));
          r.we    = ($urandom_range(0, 2) == 0);
          r.addr  = 32'($urandom_range(0, 7)) << 2;
          r.wdata = $urandom;
          r.at    = t;
          r.hold  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
          rq[g][p].push_back(r);
        end
      end
    wait_quiet("settle_rand", 6000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
